// File: rtl/prior_arb_4_pkg.sv
// Shared definitions for the 4-way priority / round-robin arbiter.
package prior_arb_4_pkg;

    localparam int unsigned NUM_REQ = 4;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        GRANT  = 2'd1,
        REVOKE = 2'd2
    } arb_state_e;

endpackage

// File: rtl/arb_pick_4.sv
// Combinational winner selection: highest set bit in fixed mode,
// first set bit ascending from start_i (with wrap) in round-robin mode.
module arb_pick_4
    import prior_arb_4_pkg::*;
(
    input  logic [3:0] elig_i,
    input  logic [1:0] start_i,
    input  logic       mode_rr_i,
    output logic [1:0] win_o,
    output logic       found_o
);

    logic [1:0] win;
    logic [1:0] idx;
    logic       hit;

    always_comb begin
        win = '0;
        idx = '0;
        hit = 1'b0;
        if (!mode_rr_i) begin
            // Ascending scan: the last set bit seen is the highest priority.
            for (int unsigned i = 0; i < NUM_REQ; i++) begin
                if (elig_i[i]) begin
                    win = 2'(i);
                    hit = 1'b1;
                end
            end
        end else begin
            for (int unsigned k = 0; k < NUM_REQ; k++) begin
                idx = start_i + 2'(k);
                if (!hit && elig_i[idx]) begin
                    win = idx;
                    hit = 1'b1;
                end
            end
        end
    end

    assign win_o   = win;
    assign found_o = hit;

endmodule

// File: rtl/prior_arb_4.sv
// 4-requester arbiter with fixed/round-robin selection, back-to-back
// handover and forced revoke after MAX_HOLD consecutive grant cycles.
module prior_arb_4
    import prior_arb_4_pkg::*;
#(
    parameter int unsigned MAX_HOLD = 8
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] req,
    input  logic       mode_rr,
    output logic [3:0] gnt,
    output logic [1:0] gnt_id,
    output logic       gnt_valid,
    output logic       timeout
);

    localparam logic [7:0] MAX_HOLD_C = 8'(MAX_HOLD);

    arb_state_e state_q, state_d;
    logic [3:0] gnt_q, gnt_d;
    logic [1:0] id_q, id_d;
    logic       valid_q, valid_d;
    logic       timeout_q, timeout_d;
    logic [7:0] hold_q, hold_d;
    logic [1:0] last_q, last_d;
    logic [3:0] excl_q, excl_d;
    logic       mode_q, mode_d;

    logic [3:0] elig;
    logic       pick_mode;
    logic [1:0] win;
    logic       found;

    // IDLE arbitrates with the live mode input and the post-revoke mask;
    // back-to-back handover in GRANT reuses the mode latched at grant time.
    always_comb begin
        elig      = req;
        pick_mode = mode_q;
        if (state_q == IDLE) begin
            elig      = req & ~excl_q;
            pick_mode = mode_rr;
        end
    end

    arb_pick_4 u_pick (
        .elig_i    (elig),
        .start_i   (last_q + 2'd1),
        .mode_rr_i (pick_mode),
        .win_o     (win),
        .found_o   (found)
    );

    always_comb begin
        state_d   = state_q;
        gnt_d     = gnt_q;
        id_d      = id_q;
        valid_d   = valid_q;
        timeout_d = 1'b0;
        hold_d    = hold_q;
        last_d    = last_q;
        excl_d    = excl_q;
        mode_d    = mode_q;
        case (state_q)
            IDLE: begin
                excl_d  = '0;
                gnt_d   = '0;
                id_d    = '0;
                valid_d = 1'b0;
                hold_d  = '0;
                mode_d  = mode_rr;
                if (found) begin
                    state_d = GRANT;
                    gnt_d   = 4'b0001 << win;
                    id_d    = win;
                    valid_d = 1'b1;
                    hold_d  = 8'd1;
                    last_d  = win;
                end
            end
            GRANT: begin
                if (req[id_q]) begin
                    if (hold_q < MAX_HOLD_C) begin
                        hold_d = hold_q + 8'd1;
                    end else begin
                        state_d   = REVOKE;
                        gnt_d     = '0;
                        id_d      = '0;
                        valid_d   = 1'b0;
                        timeout_d = 1'b1;
                        hold_d    = '0;
                        excl_d    = gnt_q;
                    end
                end else if (found) begin
                    gnt_d  = 4'b0001 << win;
                    id_d   = win;
                    valid_d = 1'b1;
                    hold_d = 8'd1;
                    last_d = win;
                end else begin
                    state_d = IDLE;
                    gnt_d   = '0;
                    id_d    = '0;
                    valid_d = 1'b0;
                    hold_d  = '0;
                end
            end
            REVOKE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
                gnt_d   = '0;
                id_d    = '0;
                valid_d = 1'b0;
                hold_d  = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            gnt_q     <= '0;
            id_q      <= '0;
            valid_q   <= 1'b0;
            timeout_q <= 1'b0;
            hold_q    <= '0;
            last_q    <= 2'd3;
            excl_q    <= '0;
            mode_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            gnt_q     <= gnt_d;
            id_q      <= id_d;
            valid_q   <= valid_d;
            timeout_q <= timeout_d;
            hold_q    <= hold_d;
            last_q    <= last_d;
            excl_q    <= excl_d;
            mode_q    <= mode_d;
        end
    end

    assign gnt       = gnt_q;
    assign gnt_id    = id_q;
    assign gnt_valid = valid_q;
    assign timeout   = timeout_q;

endmodule
